// File: rtl/decode_pipe_stage.sv
// Decode stage: register file with write-through bypass, operand and immediate
// preparation, D/E pipeline register with stall/flush, and load-use detection.
module decode_pipe_stage #(
  parameter  int WIDTH  = 32,
  parameter  int NREGS  = 16,
  parameter  int PC_REG = 15,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      InstructionD,
  input  logic [WIDTH-1:0] PCPlus8D,
  input  logic [1:0]       RegSrcD,
  input  logic [1:0]       ImmSrcD,
  input  logic             MemtoRegD,
  input  logic             validD,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             RegWriteW,
  input  logic [AW-1:0]    WA3W,
  input  logic [WIDTH-1:0] ResultW,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [WIDTH-1:0] ExtImmE,
  output logic [AW-1:0]    RA1E,
  output logic [AW-1:0]    RA2E,
  output logic [AW-1:0]    WA3E,
  output logic             MemtoRegE,
  output logic             validE,
  output logic             ldStallD
);

  localparam logic [AW-1:0] PC_IDX = AW'(PC_REG);

  logic [WIDTH-1:0] regs_reg [NREGS];

  logic [AW-1:0]    ra_d [2];
  logic [WIDTH-1:0] rd_d [2];
  logic [AW-1:0]    wa3_d;
  logic [WIDTH-1:0] ext_imm_d;
  logic signed [25:0] branch_off;

  logic [WIDTH-1:0] rd1_e_reg, rd2_e_reg, ext_imm_e_reg;
  logic [AW-1:0]    ra1_e_reg, ra2_e_reg, wa3_e_reg;
  logic             mem_to_reg_e_reg, valid_e_reg;

  // Top instruction byte carries no register or immediate fields here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^InstructionD[31:24];

  assign ra_d[0] = RegSrcD[0] ? PC_IDX : AW'(InstructionD[19:16]);
  assign ra_d[1] = RegSrcD[1] ? AW'(InstructionD[15:12]) : AW'(InstructionD[3:0]);
  assign wa3_d   = AW'(InstructionD[15:12]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (RegWriteW && (WA3W != PC_IDX)) begin
      regs_reg[WA3W] <= ResultW;
    end
  end

  // PC alias outranks the bypass, so a write aimed at PC_REG is never visible.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      assign rd_d[gi] = (ra_d[gi] == PC_IDX)                ? PCPlus8D :
                        (RegWriteW && (WA3W == ra_d[gi]))    ? ResultW  :
                                                               regs_reg[ra_d[gi]];
    end
  endgenerate

  assign branch_off = {InstructionD[23:0], 2'b00};

  always_comb begin
    ext_imm_d = '0;
    case (ImmSrcD)
      2'b00:   ext_imm_d = WIDTH'(InstructionD[7:0]);
      2'b01:   ext_imm_d = WIDTH'(InstructionD[11:0]);
      2'b10:   ext_imm_d = WIDTH'(branch_off);
      default: ext_imm_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || flushE) begin
      rd1_e_reg        <= '0;
      rd2_e_reg        <= '0;
      ext_imm_e_reg    <= '0;
      ra1_e_reg        <= '0;
      ra2_e_reg        <= '0;
      wa3_e_reg        <= '0;
      mem_to_reg_e_reg <= 1'b0;
      valid_e_reg      <= 1'b0;
    end else if (!stallE) begin
      rd1_e_reg        <= rd_d[0];
      rd2_e_reg        <= rd_d[1];
      ext_imm_e_reg    <= ext_imm_d;
      ra1_e_reg        <= ra_d[0];
      ra2_e_reg        <= ra_d[1];
      wa3_e_reg        <= wa3_d;
      mem_to_reg_e_reg <= MemtoRegD;
      valid_e_reg      <= validD;
    end
  end

  assign RD1E      = rd1_e_reg;
  assign RD2E      = rd2_e_reg;
  assign ExtImmE   = ext_imm_e_reg;
  assign RA1E      = ra1_e_reg;
  assign RA2E      = ra2_e_reg;
  assign WA3E      = wa3_e_reg;
  assign MemtoRegE = mem_to_reg_e_reg;
  assign validE    = valid_e_reg;

  assign ldStallD = mem_to_reg_e_reg & valid_e_reg & validD &
                    ((ra_d[0] == wa3_e_reg) | (ra_d[1] == wa3_e_reg));

endmodule
